lsu_axi_wr_responder: RTL

// - AXI4 write-channel responder (slave) for the BrqRV EB1 LSU write master inside the user project.
// - Replaces the tied-off awready/wready/bvalid with a real AW -> W -> B handshake.
// - Commits single-beat, in-window writes into a 64-bit output register that drives the GPIO/LA output muxes.
// - Returns a proper B response (OKAY/SLVERR/DECERR) with the matching ID.

---
 rtl/lsu_axi_pkg.sv | 19 +
 rtl/lsu_axi_wr_strb_merge.sv | 32 +++
 rtl/lsu_axi_wr_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_axi_pkg.sv
// Shared definitions for the LSU AXI write responder.
// Holds the AXI data/strobe widths, the B-channel response codes and the
// responder state encoding used by the top and its merge sub-module.
package lsu_axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_axi_wr_strb_merge.sv
// Combinational byte-strobe merge for the 64-bit output register.
// Ports:
//   cur_data  - current output register contents
//   cur_word  - current selected 32-bit half
//   wdata     - incoming write data
//   wstrb     - byte strobes, one per byte of wdata
//   merged    - cur_data with strobed bytes replaced by wdata
//   word      - low half if any low strobe set, else high half if any high
//               strobe set, else cur_word unchanged
module lsu_axi_wr_strb_merge
  import lsu_axi_pkg::*;
(
  input  logic [AXI_DATA_W-1:0] cur_data,
  input  logic [31:0]           cur_word,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  output logic [AXI_DATA_W-1:0] merged,
  output logic [31:0]           word
);

  generate
    for (genvar gi = 0; gi < AXI_STRB_W; gi++) begin : g_byte
      assign merged[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : cur_data[8*gi +: 8];
    end
  endgenerate

  // The low half wins when both halves are strobed.
  assign word = (|wstrb[3:0]) ? merged[31:0]  :
                (|wstrb[7:4]) ? merged[63:32] :
                                cur_word;

endmodule

// File: rtl/lsu_axi_wr_responder.sv
// AXI4 write-channel responder for the LSU write master.
// Accepts one AW, then W beats until wlast, then returns a B response.
// Single-beat writes that decode into the output window are merged into a
// 64-bit output register; everything else is answered with SLVERR/DECERR.
// Ports:
//   wb_clk_i / wb_rst_i           - clock, synchronous active-high reset
//   aw*, w*, b*                   - AXI4 write address/data/response channels
//   out_data_o                    - committed 64-bit output register
//   out_word_o                    - 32-bit half selected by the last commit
//   out_strobe_o                  - one-cycle pulse when outputs update
//   wr_count_o                    - number of OKAY responses (wrapping)
module lsu_axi_wr_responder
  import lsu_axi_pkg::*;
#(
  parameter int          ID_W      = 3,
  parameter logic [31:0] BASE_ADDR = 32'hD000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0FFF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       awid,
  input  logic [31:0]           awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic [ID_W-1:0]       bid,
  output logic [AXI_DATA_W-1:0] out_data_o,
  output logic [31:0]           out_word_o,
  output logic                  out_strobe_o,
  output logic [15:0]           wr_count_o
);

  state_t                state_reg;
  logic [ID_W-1:0]       id_reg;
  logic [7:0]            len_reg;
  logic                  hit_reg;
  logic                  size_ok_reg;
  logic [7:0]            beat_reg;
  logic [1:0]            bresp_reg;
  logic [AXI_DATA_W-1:0] out_data_reg;
  logic [31:0]           out_word_reg;
  logic                  out_strobe_reg;
  logic [15:0]           wr_count_reg;

  logic                  hit;
  logic [7:0]            beat_next;
  logic                  len_match;
  logic [1:0]            resp_sel;
  logic                  commit;
  logic [AXI_DATA_W-1:0] merged;
  logic [31:0]           word_next;

  assign hit = ((awaddr & ~ADDR_MASK) == BASE_ADDR);

  // Beat count including the beat currently on the bus, saturating at 255.
  assign beat_next = (beat_reg == 8'hFF) ? 8'hFF : beat_reg + 8'd1;

  // 9-bit compare so awlen=255 (256 beats) can never look like a match.
  assign len_match = ({1'b0, beat_next} == ({1'b0, len_reg} + 9'd1));

  always_comb begin
    resp_sel = BRESP_OKAY;
    if (!hit_reg) begin
      resp_sel = BRESP_DECERR;
    end else if ((len_reg != 8'd0) || !size_ok_reg || !len_match) begin
      resp_sel = BRESP_SLVERR;
    end
  end

  // Only a write that will be answered OKAY touches the output register,
  // which also keeps a single-beat write with a late wlast from committing.
  assign commit = (state_reg == ST_DATA) && wvalid && wlast && (resp_sel == BRESP_OKAY);

  lsu_axi_wr_strb_merge u_merge (
    .cur_data (out_data_reg),
    .cur_word (out_word_reg),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .merged   (merged),
    .word     (word_next)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= ST_IDLE;
      id_reg         <= '0;
      len_reg        <= '0;
      hit_reg        <= 1'b0;
      size_ok_reg    <= 1'b0;
      beat_reg       <= '0;
      bresp_reg      <= BRESP_OKAY;
      out_data_reg   <= '0;
      out_word_reg   <= '0;
      out_strobe_reg <= 1'b0;
      wr_count_reg   <= '0;
    end else begin
      out_strobe_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // awready is high throughout IDLE once out of reset.
          if (awvalid) begin
            id_reg      <= awid;
            len_reg     <= awlen;
            hit_reg     <= hit;
            size_ok_reg <= (awsize <= 3'd3);
            beat_reg    <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wvalid) begin
            beat_reg <= beat_next;
            if (wlast) begin
              bresp_reg <= resp_sel;
              state_reg <= ST_RESP;
              if (commit) begin
                out_data_reg   <= merged;
                out_word_reg   <= word_next;
                out_strobe_reg <= |wstrb;
              end
            end
          end
        end
        ST_RESP: begin
          if (bready) begin
            state_reg <= ST_IDLE;
            if (bresp_reg == BRESP_OKAY) begin
              wr_count_reg <= wr_count_reg + 16'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign awready      = (state_reg == ST_IDLE) && !wb_rst_i;
  assign wready       = (state_reg == ST_DATA);
  assign bvalid       = (state_reg == ST_RESP);
  assign bresp        = bresp_reg;
  assign bid          = id_reg;
  assign out_data_o   = out_data_reg;
  assign out_word_o   = out_word_reg;
  assign out_strobe_o = out_strobe_reg;
  assign wr_count_o   = wr_count_reg;

endmodule
